// File: rtl/rate_counter_sequencer.sv
// Rate counter sequencer: run/pause/step control for the display digit counter.
// A programmable down-counter sets the advance rate. The digit counter steps once
// per tick. A new speed takes effect only at a tick boundary while running.
module rate_counter_sequencer #(
    parameter int DIV_W    = 27,
    parameter int DIV_FAST = 25000000,
    parameter int DIV_MID  = 50000000,
    parameter int DIV_SLOW = 100000000,
    parameter int CNT_MAX  = 15
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] speed,
    input  logic       go,
    input  logic       halt,
    input  logic       step,
    input  logic       clear,
    output logic       tick,
    output logic [3:0] count,
    output logic       wrap,
    output logic       running,
    output logic       speed_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        STEP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [DIV_W-1:0] r_rdiv;
    logic [DIV_W-1:0] w_rdivNext;
    logic [3:0]       r_count;
    logic [3:0]       w_countNext;
    logic [1:0]       r_activeSpeed;
    logic [1:0]       w_activeSpeedNext;
    logic             r_tick;
    logic             w_tickNext;
    logic             r_wrap;
    logic             w_wrapNext;
    logic             r_speedAck;
    logic             w_speedAckNext;

    logic             w_speedChange;
    logic [DIV_W-1:0] w_reloadActive;
    logic [DIV_W-1:0] w_reloadReq;
    logic             w_atMax;
    logic [3:0]       w_countInc;

    // Reload value (period minus one) for a given speed code
    function automatic logic [DIV_W-1:0] reloadFor(input logic [1:0] s);
        case (s)
            2'b01:   reloadFor = DIV_W'(DIV_FAST - 1);
            2'b10:   reloadFor = DIV_W'(DIV_MID - 1);
            2'b11:   reloadFor = DIV_W'(DIV_SLOW - 1);
            default: reloadFor = '0;
        endcase
    endfunction

    assign w_speedChange  = (speed != r_activeSpeed);
    assign w_reloadActive = reloadFor(r_activeSpeed);
    assign w_reloadReq    = reloadFor(speed);
    assign w_atMax        = (r_count == 4'(CNT_MAX));
    assign w_countInc     = w_atMax ? 4'd0 : (r_count + 4'd1);

    // State, divider, counter and pulse registers; reset discards everything at once
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rdiv        <= '0;
            r_count       <= 4'd0;
            r_activeSpeed <= 2'b00;
            r_tick        <= 1'b0;
            r_wrap        <= 1'b0;
            r_speedAck    <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_rdiv        <= w_rdivNext;
            r_count       <= w_countNext;
            r_activeSpeed <= w_activeSpeedNext;
            r_tick        <= w_tickNext;
            r_wrap        <= w_wrapNext;
            r_speedAck    <= w_speedAckNext;
        end
    end

    // Next-state and datapath decisions; clear beats halt beats step beats go.
    // clear is honoured in every state, including the single-cycle STEP state.
    // A pending speed change is left for the following cycle when clear wins.
    always_comb begin
        w_stateNext       = r_state;
        w_rdivNext        = r_rdiv;
        w_countNext       = r_count;
        w_activeSpeedNext = r_activeSpeed;
        w_tickNext        = 1'b0;
        w_wrapNext        = 1'b0;
        w_speedAckNext    = 1'b0;

        if (clear) begin
            w_countNext = 4'd0;
            w_rdivNext  = w_reloadActive;
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE, PAUSE: begin
                    if (r_state == IDLE) begin
                        w_rdivNext = w_reloadActive;
                    end
                    if (w_speedChange) begin
                        w_activeSpeedNext = speed;
                        w_rdivNext        = w_reloadReq;
                        w_speedAckNext    = 1'b1;
                    end
                    if (!halt) begin
                        if (step) begin
                            w_stateNext = STEP;
                        end else if (go) begin
                            w_stateNext = RUN;
                        end
                    end
                end
                RUN: begin
                    if (halt) begin
                        w_stateNext = PAUSE;
                    end else if (r_rdiv == '0) begin
                        w_tickNext  = 1'b1;
                        w_countNext = w_countInc;
                        w_wrapNext  = w_atMax;
                        if (w_speedChange) begin
                            w_activeSpeedNext = speed;
                            w_rdivNext        = w_reloadReq;
                            w_speedAckNext    = 1'b1;
                        end else begin
                            w_rdivNext = w_reloadActive;
                        end
                    end else begin
                        w_rdivNext = r_rdiv - DIV_W'(1);
                    end
                end
                STEP: begin
                    w_tickNext  = 1'b1;
                    w_countNext = w_countInc;
                    w_wrapNext  = w_atMax;
                    w_rdivNext  = w_reloadActive;
                    w_stateNext = PAUSE;
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    assign tick      = r_tick;
    assign count     = r_count;
    assign wrap      = r_wrap;
    assign speed_ack = r_speedAck;
    assign running   = (r_state == RUN);

endmodule
